// File: rtl/hazard_fwd_ctrl_pkg.sv
// ============================================================================
// hazard_pkg : shared types and select codes for the ID/EX hazard controller
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int HZ_REG_AW = 5;

    // EX operand-mux select encoding; 2'b11 is never driven.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [HZ_REG_AW-1:0] wdst;
        logic                 is_load;
    } slot_t;

    localparam slot_t BUBBLE = '{valid: 1'b0, wen: 1'b0, wdst: '0, is_load: 1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// ============================================================================
// fwd_match : compares one ID source operand against the EX and MEM slots
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fwd_match
    import hazard_pkg::*;
(
    input  logic [HZ_REG_AW-1:0] i_reg,
    input  logic                 i_use,
    input  slot_t                i_ex,
    input  slot_t                i_mem,
    output logic                 o_ex_hit,
    output logic                 o_mem_hit,
    output logic                 o_load_hit
);

    logic w_live;

    // $0 is hardwired, so it never creates a dependency.
    assign w_live     = i_use && (i_reg != '0);
    assign o_ex_hit   = w_live && i_ex.valid  && i_ex.wen  && (i_ex.wdst  == i_reg);
    assign o_mem_hit  = w_live && i_mem.valid && i_mem.wen && (i_mem.wdst == i_reg);
    assign o_load_hit = o_ex_hit && i_ex.is_load;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// hazard_fwd_ctrl : ID/EX hazard detection and operand-forwarding control
//                   Optional feature macro: HAZ_FORWARD_EN (forwarding paths)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_wdst,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic [SEL_W-1:0]  ex_fwd_a,
    output logic [SEL_W-1:0]  ex_fwd_b,
    output logic              ex_bubble
);

    slot_t            r_ex;
    slot_t            r_mem;
    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;
    logic             r_bubble;

    logic w_ex_a, w_mem_a, w_ld_a;
    logic w_ex_b, w_mem_b, w_ld_b;
    logic             w_haz;
    logic             w_issue;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;

    fwd_match u_match_rs (
        .i_reg      (id_rs),
        .i_use      (id_use_rs),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .o_ex_hit   (w_ex_a),
        .o_mem_hit  (w_mem_a),
        .o_load_hit (w_ld_a)
    );

    fwd_match u_match_rt (
        .i_reg      (id_rt),
        .i_use      (id_use_rt),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .o_ex_hit   (w_ex_b),
        .o_mem_hit  (w_mem_b),
        .o_load_hit (w_ld_b)
    );

`ifdef HAZ_FORWARD_EN
    // Youngest producer wins: an EX-slot match beats a MEM-slot match.
    assign w_haz   = w_ld_a || w_ld_b;
    assign w_sel_a = w_ex_a ? FWD_MEM : (w_mem_a ? FWD_WB : FWD_RF);
    assign w_sel_b = w_ex_b ? FWD_MEM : (w_mem_b ? FWD_WB : FWD_RF);
`else
    // Without bypass paths the consumer waits until its producer reaches WB.
    logic w_unused_ld;
    assign w_unused_ld = w_ld_a ^ w_ld_b;
    assign w_haz   = w_ex_a || w_ex_b || w_mem_a || w_mem_b;
    assign w_sel_a = FWD_RF;
    assign w_sel_b = FWD_RF;
`endif

    assign stall   = !rst && id_valid && !flush && w_haz;
    assign w_issue = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex     <= BUBBLE;
            r_mem    <= BUBBLE;
            r_fwd_a  <= FWD_RF;
            r_fwd_b  <= FWD_RF;
            r_bubble <= 1'b1;
        end else if (!freeze) begin
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex.valid   <= 1'b1;
                r_ex.wen     <= id_wen;
                r_ex.wdst    <= id_wdst;
                r_ex.is_load <= id_is_load;
                r_fwd_a      <= w_sel_a;
                r_fwd_b      <= w_sel_b;
                r_bubble     <= 1'b0;
            end else begin
                r_ex     <= BUBBLE;
                r_fwd_a  <= FWD_RF;
                r_fwd_b  <= FWD_RF;
                r_bubble <= 1'b1;
            end
        end
    end

    assign ex_fwd_a  = r_fwd_a;
    assign ex_fwd_b  = r_fwd_b;
    assign ex_bubble = r_bubble;

endmodule

`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage MIPS core. Sits at the ID/EX boundary. It tracks the destination registers of instructions in EX and MEM. It produces the registered 2-bit operand-select codes that drive the two EX-stage 3-to-1 operand muxes (ALU A and ALU B). It also raises the combinational load-use stall toward PC/IF-ID and inserts bubbles into EX.

## Interface
Parameters:
- REG_AW, 5, register-address width
- SEL_W, 2, operand-select width (fixed encoding below)

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source registers of ID instruction
- id_use_rs, id_use_rt  in  1  instruction actually reads rs/rt
- id_wen  in  1  ID instruction writes a register
- id_wdst  in  REG_AW  its destination register (already rd/rt-resolved)
- id_is_load  in  1  ID instruction is lw/lb/lh
- flush  in  1  squash ID instruction (taken branch/jump)
- freeze  in  1  global hold (memory wait); all state holds
- stall  out  1  combinational; hold PC and IF/ID, bubble EX
- ex_fwd_a, ex_fwd_b  out  SEL_W  registered select for EX operand muxes
- ex_bubble  out  1  registered; EX slot is a bubble

## Operation
- Select encoding, decided: 00 = register-file value, 01 = MEM/WB result, 10 = EX/MEM ALU result. 11 is never driven.
- Internal slots: EX slot and MEM slot, each holding {valid, wen, wdst, is_load}.
- Per edge when freeze=0:
  - MEM slot ← EX slot.
  - EX slot ← ID fields if id_valid & !stall & !flush; otherwise EX slot ← bubble (valid=0).
- Match on operand X (rs or rt): id_use_X & slot.valid & slot.wen & slot.wdst==X & X!=0.
- Forward select, computed in ID and registered into ex_fwd_* with the EX slot:
  - EX-slot match → 10, because the producer is in EX/MEM when the consumer reaches EX.
  - Else MEM-slot match → 01.
  - Else 00.
  - EX-slot match has priority (youngest producer).
- Load-use: stall=1 when id_valid & !flush & an EX-slot match with EX.is_load=1, on either operand. Stall lasts exactly one cycle. The load then sits in MEM, so the re-evaluated select becomes 01.
- flush and a stall condition in the same cycle: flush wins, stall=0, EX gets a bubble.
- freeze=1: slots, ex_fwd_*, and ex_bubble hold. stall still reflects the current hazard (PC is frozen anyway).
- Bubble entering EX: ex_fwd_a/b=00, ex_bubble=1.
- Register file is write-through (WB write visible to ID read the same cycle). No third forwarding level is needed.

## Timing
- Reset (rst=1 at edge): both slots invalid, ex_fwd_a=ex_fwd_b=00, ex_bubble=1. While rst=1, stall is forced to 0.
- stall: zero latency, combinational from ID inputs and slot state.
- ex_fwd_*, ex_bubble: one-cycle latency. Valid during the cycle the instruction occupies EX.
- Reset mid-stall: the next cycle stall=0 and the slots are empty. A pending load is discarded.
- Back-to-back loads feeding each other: each consumer stalls exactly one cycle.

## Configuration
- HAZ_FORWARD_EN defined: forwarding as above; only load-use stalls.
- Undefined:
  - ex_fwd_a/b are tied to 00.
  - stall=1 whenever any EX-slot or MEM-slot match exists (load or not).
  - The consumer stalls up to 2 cycles, until the producer reaches WB.
  - flush and freeze rules are unchanged.

## Structure
- Shared package `hazard_pkg`:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - slot struct {valid, wen, wdst, is_load}
  - BUBBLE slot constant
- One sub-module `fwd_match`: compares one source operand against both slots. Outputs the EX-match, MEM-match, and load-hit flags. Instantiated twice (rs, rt).

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → when sub is in EX, ex_fwd_a=10, stall never asserted.
- `add $3`, `nop`, `or $6,$7,$3` → or in EX with ex_fwd_b=01, ex_fwd_a=00.
- `lw $8,0($1)` then `add $9,$8,$8` → stall=1 for one cycle, ex_bubble=1 next, then ex_fwd_a=ex_fwd_b=01.
- `addi $3` twice back-to-back, then `add $4,$3,$0` → ex_fwd_a=10 (younger wins). Writes and reads to $0 → select 00.
- lw followed by dependent use with flush=1 in the same cycle → stall=0, EX bubble. Assert rst mid-stall → stall=0 and ex_fwd=00 the next cycle.
- HAZ_FORWARD_EN undefined: `add $3` then `sub $4,$3,$5` → stall=1 for exactly 2 cycles, ex_fwd_a=00 throughout.
